psum_collector: RTL and testbench

Output-side companion of the 16x16 weight-stationary PE array. The feeder issues one input vector per accepted cycle. The collector tracks each vector through the array's fixed pipeline latency and captures the matching bottom-row partial-sum vector. It buffers results in a FIFO and presents them on a valid/ready stream, using credit-based admission so the non-stallable array can never overrun the buffer. It also reports `idle` so the weight loader knows when a column reload cannot corrupt in-flight vectors.

---
 rtl/psum_collector.sv | 86 ++++++++
 tb/tb_psum_collector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// Captures bottom-row partial sums of the PE array a fixed LATENCY after issue and
// buffers them in a credit-guarded FIFO so the non-stallable array can never overrun it.
module psum_collector #(
  parameter int ARRAY_DIM  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           idle,
  output logic                           overflow
);
  localparam int DW = ARRAY_DIM * ACC_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] last_pipe;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW:0]        credit_used;
  entry_t             mem [FIFO_DEPTH];
  entry_t             head;
  logic               issue;
  logic               capture;
  logic               pop;
  logic               push;

  // Credit counts both buffered and in-flight vectors, so a capture always has a slot.
  assign credit_used = (CW + 1)'(fifo_count) + (CW + 1)'(inflight);
  assign in_ready    = !rst && (credit_used < DEPTH_C);
  assign issue       = in_valid && in_ready;
  assign capture     = vld_pipe[LATENCY-1];
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid && out_ready;
  assign push        = capture && ((fifo_count != FULL_C) || pop);
  assign idle        = (inflight == '0) && (fifo_count == '0);

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.data : '0;
  assign out_last = out_valid ? head.last : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[LATENCY-2:0], issue};
      last_pipe  <= {last_pipe[LATENCY-2:0], in_last};
      inflight   <= inflight + IW'(issue) - IW'(capture);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (capture && (fifo_count == FULL_C) && !pop) overflow <= 1'b1;
    end
  end

  // Storage is not reset; the outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: last_pipe[LATENCY-1], data: psum_in};
  end
endmodule

// File: tb/tb_psum_collector.sv
// Randomized bench for psum_collector: a queue-based model of issue timing, credit and
// FIFO order predicts every visible output.
module tb_psum_collector;
  localparam int DIM   = 16;
  localparam int AW    = 32;
  localparam int LAT   = 16;
  localparam int DEPTH = 32;
  localparam int DW    = DIM * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] psum_in;
  logic          out_valid, out_ready, out_last, idle, overflow;
  logic [DW-1:0] out_data;

  psum_collector #(.ARRAY_DIM(DIM), .ACC_WIDTH(AW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .idle(idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic last; } pend_t;
  typedef struct { logic [DW-1:0] data; logic last; } res_t;

  pend_t pend[$];
  res_t  mfifo[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  logic  movf = 1'b0;

  function automatic logic [DW-1:0] rand_psum();
    logic [DW-1:0] v;
    for (int c = 0; c < DIM; c++) v[c*AW +: AW] = $urandom;
    return v;
  endfunction

  // One clock edge of the reference model; returns 1 ns after the edge.
  task automatic step();
    logic iss, pp, lst;
    logic [DW-1:0] d;
    pend_t pe;
    iss = !rst && in_valid && ((mfifo.size() + pend.size()) < DEPTH);
    pp  = !rst && out_ready && (mfifo.size() != 0);
    lst = in_last;
    d   = psum_in;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mfifo.delete();
      pend.delete();
    end else begin
      if (pp) void'(mfifo.pop_front());
      if (pend.size() != 0 && pend[0].due == cyc) begin
        pe = pend.pop_front();
        if (mfifo.size() < DEPTH) mfifo.push_back('{data: d, last: pe.last});
        else movf = 1'b1;
      end
      if (iss) pend.push_back('{due: cyc + LAT, last: lst});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; psum_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", in_ready); end
    rst = 1'b0;
    mfifo.delete(); pend.delete();
    #1;
    total++;
    if ({in_ready, out_valid, out_last, idle, overflow} !== 5'b10010) begin
      bad++;
      $display("FAIL reset_flags got ready/valid/last/idle/ovf=%b%b%b%b%b exp=10010",
               in_ready, out_valid, out_last, idle, overflow);
    end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
  endtask

  task automatic test_single();
    logic [DW-1:0] pat;
    for (int c = 0; c < DIM; c++) pat[c*AW +: AW] = AW'(c + 1);
    in_valid = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if (idle !== 1'b0) begin bad++; $display("FAIL single_idle_fall got=%b exp=0", idle); end
    repeat (LAT - 1) step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    psum_in = pat;
    step();
    psum_in = '0;
    total++;
    if (out_valid !== 1'b1 || out_last !== 1'b1) begin
      bad++; $display("FAIL single_valid_last got valid=%b last=%b exp 1 1", out_valid, out_last);
    end
    total++;
    if (out_data !== pat) begin bad++; $display("FAIL single_data got=%h exp=%h", out_data, pat); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (idle !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL single_after_pop got idle=%b valid=%b exp 1 0", idle, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n_iss = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_last = 1'($urandom); psum_in = rand_psum();
      if (in_ready) n_iss++;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (n_iss !== DEPTH) begin bad++; $display("FAIL bp_issue_count got=%0d exp=%0d", n_iss, DEPTH); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    repeat (LAT) begin psum_in = rand_psum(); step(); end
    total++;
    if (dut.fifo_count !== 6'(DEPTH)) begin
      bad++; $display("FAIL bp_fifo_count got=%0d exp=%0d", dut.fifo_count, DEPTH);
    end
    total++;
    if (overflow !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_flags got ovf=%b valid=%b exp 0 1", overflow, out_valid);
    end
  endtask

  task automatic test_drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < DEPTH + 4) begin
      total++;
      if (mfifo.size() == 0 || out_data !== mfifo[0].data || out_last !== mfifo[0].last) begin
        bad++; $display("FAIL drain_entry idx=%0d got last=%b data=%h", n, out_last, out_data);
      end
      step();
      n++;
      if (n == 1) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_credit got=%b exp=1", in_ready); end
      end
    end
    out_ready = 1'b0;
    total++;
    if (n !== DEPTH) begin bad++; $display("FAIL drain_count got=%0d exp=%0d", n, DEPTH); end
    total++;
    if (idle !== 1'b1) begin bad++; $display("FAIL drain_idle got=%b exp=1", idle); end
  endtask

  task automatic test_full_pushpop();
    int guard = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (DEPTH) begin in_last = 1'($urandom); psum_in = rand_psum(); step(); end
    in_valid = 1'b0;
    while (mfifo.size() < DEPTH - 1 && guard < 100) begin psum_in = rand_psum(); step(); guard++; end
    total++;
    if (guard >= 100) begin bad++; $display("FAIL fp_fill_timeout got=%0d exp<100", guard); end
    total++;
    if (dut.fifo_count !== 6'(DEPTH - 1)) begin
      bad++; $display("FAIL fp_pre_count got=%0d exp=%0d", dut.fifo_count, DEPTH - 1);
    end
    out_ready = 1'b1; psum_in = rand_psum();
    step();
    out_ready = 1'b0;
    total++;
    if (dut.fifo_count !== 6'(DEPTH - 1) || overflow !== 1'b0) begin
      bad++; $display("FAIL fp_pushpop got count=%0d ovf=%b exp %0d 0", dut.fifo_count, overflow, DEPTH - 1);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL fp_credit got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      total++;
      if (mfifo.size() == 0 || out_valid !== 1'b1 || out_data !== mfifo[0].data || out_last !== mfifo[0].last) begin
        bad++; $display("FAIL fp_drain idx=%0d got valid=%b last=%b", i, out_valid, out_last);
      end
      step();
    end
    out_ready = 1'b0;
    total++;
    if (idle !== 1'b1) begin bad++; $display("FAIL fp_idle got=%b exp=1", idle); end
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (5) begin psum_in = rand_psum(); in_last = 1'($urandom); step(); end
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    mfifo.delete(); pend.delete();
    #1;
    total++;
    if (in_ready !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL rmf_in_reset got ready=%b idle=%b exp 0 1", in_ready, idle);
    end
    step(); step();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || idle !== 1'b1) begin
      bad++; $display("FAIL rmf_release got ready=%b idle=%b exp 1 1", in_ready, idle);
    end
    repeat (30) begin
      psum_in = rand_psum(); step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rmf_ghost_output got=%b exp=0", seen); end
  endtask

  task automatic test_random();
    int p_valid = 50, p_ready = 50;
    logic [3:0] exp_ctrl;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) begin p_valid = $urandom_range(10, 100); p_ready = $urandom_range(5, 100); end
      in_valid  = ($urandom_range(1, 100) <= p_valid);
      in_last   = 1'($urandom);
      out_ready = ($urandom_range(1, 100) <= p_ready);
      psum_in   = rand_psum();
      step();
      exp_ctrl = {((mfifo.size() + pend.size()) < DEPTH), (mfifo.size() != 0),
                  (mfifo.size() == 0 && pend.size() == 0), movf};
      total++;
      if ({in_ready, out_valid, idle, overflow} !== exp_ctrl) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got ready/valid/idle/ovf=%b exp=%b",
                        cyc, {in_ready, out_valid, idle, overflow}, exp_ctrl);
      end
      if (mfifo.size() != 0) begin
        total++;
        if (out_data !== mfifo[0].data || out_last !== mfifo[0].last) begin
          bad++; $display("FAIL rnd_data cyc=%0d got last=%b data=%h exp last=%b data=%h",
                          cyc, out_last, out_data, mfifo[0].last, mfifo[0].data);
        end
      end
      total++;
      if (32'(dut.fifo_count) + 32'(dut.inflight) > DEPTH) begin
        bad++; $display("FAIL rnd_credit_bound cyc=%0d got=%0d exp<=%0d", cyc,
                        32'(dut.fifo_count) + 32'(dut.inflight), DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_drain();
    test_full_pushpop();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=time_expired exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
